// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, serial line levels and a parity helper.
// Used by uart_tx and intended for reuse by the matching receiver.
package uart_pkg;

  // Symbol-oriented frame states; StParity is only reachable when parity is compiled in.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Line levels for the non-data symbols.
  localparam logic LineIdle  = 1'b1;
  localparam logic LineStart = 1'b0;
  localparam logic LineStop  = 1'b1;

  // Wide enough for the largest data field (9 bits -> count 0..8).
  localparam int unsigned CntWidth = 4;

  // Parity over up to 9 data bits (zero-extend narrower words); odd sense inverts it.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: accepts a word on a valid/ready handshake and shifts it out LSB first
// as start, data, optional parity and stop symbols, one symbol per baud_tick.
// Optional parity is compiled in with the macro UART_TX_PARITY_EN.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam logic [CntWidth-1:0] LastData = CntWidth'(DATA_BITS - 1);
  localparam logic [CntWidth-1:0] LastStop = CntWidth'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 tx_q, tx_d;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`else
  // Parity sense has no meaning without the parity symbol.
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  // State register; reset forces the line idle and aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
      tx_q    <= LineIdle;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic. Each state names the symbol currently on the line (StStart also covers
  // the wait before the start bit); a tick launches the following symbol.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    unique case (state_q)
      StIdle: begin
        tx_d  = LineIdle;
        cnt_d = '0;
        // Ticks here are ignored, including one coinciding with the accept.
        if (tx_valid) begin
          shreg_d = tx_data;
`ifdef UART_TX_PARITY_EN
          par_d   = parity_bit(9'(tx_data), PARITY_ODD);
`endif
          state_d = StStart;
        end
      end

      StStart: begin
        if (baud_tick) begin
          // Line still idle means the start bit has not been launched yet.
          if (tx_q == LineIdle) begin
            tx_d = LineStart;
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
            cnt_d   = '0;
            state_d = StData;
          end
        end
      end

      StData: begin
        if (baud_tick) begin
          if (cnt_q != LastData) begin
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = StParity;
`else
            tx_d    = LineStop;
            state_d = StStop;
`endif
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_tick) begin
          tx_d    = LineStop;
          cnt_d   = '0;
          state_d = StStop;
        end
      end
`endif

      StStop: begin
        if (baud_tick) begin
          if (cnt_q != LastStop) begin
            tx_d  = LineStop;
            cnt_d = cnt_q + 1'b1;
          end else begin
            // This tick ends the last stop bit; the line stays high into idle.
            tx_d    = LineIdle;
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
      end

      default: begin
        // Unreachable encodings recover to a clean idle line.
        tx_d    = LineIdle;
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Handshake and status derive directly from the registered state.
  always_comb begin
    tx_ready = (state_q == StIdle);
    tx_busy  = (state_q != StIdle);
    tx       = tx_q;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: two instances, one with a software-driven
// baud tick (1 stop bit, even parity sense) and one with the tick tied high (2 stop bits,
// odd parity sense). Expected frames are hand-computed, LSB = start bit.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int          P     = 1;
  localparam logic [15:0] FrA5  = 16'h054A;
  localparam logic [15:0] Fr00  = 16'h0400;
  localparam logic [15:0] FrFF  = 16'h05FE;
  localparam logic [15:0] Fr5A  = 16'h04B4;
  localparam logic [15:0] FrC3  = 16'h0586;
  localparam logic [15:0] Fr3C  = 16'h0E78;
  localparam logic [15:0] Fr01  = 16'h0C02;
`else
  localparam int          P     = 0;
  localparam logic [15:0] FrA5  = 16'h034A;
  localparam logic [15:0] Fr00  = 16'h0200;
  localparam logic [15:0] FrFF  = 16'h03FE;
  localparam logic [15:0] Fr5A  = 16'h02B4;
  localparam logic [15:0] FrC3  = 16'h0386;
  localparam logic [15:0] Fr3C  = 16'h0678;
  localparam logic [15:0] Fr01  = 16'h0602;
`endif
  localparam int N1 = 10 + P;  // symbols per frame, 1 stop bit
  localparam int N2 = 11 + P;  // symbols per frame, 2 stop bits

  logic       clk, rst, tick;
  logic [7:0] data, data2;
  logic       valid, ready, tx, busy;
  logic       valid2, ready2, tx2, busy2;

  int checks  = 0;
  int passes  = 0;
  int fails   = 0;
  int low_cnt = 0;

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1'b0)) dut (
    .clk      (clk),
    .rst      (rst),
    .baud_tick(tick),
    .tx_data  (data),
    .tx_valid (valid),
    .tx_ready (ready),
    .tx       (tx),
    .tx_busy  (busy)
  );

  uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1'b1)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .baud_tick(1'b1),
    .tx_data  (data2),
    .tx_valid (valid2),
    .tx_ready (ready2),
    .tx       (tx2),
    .tx_busy  (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (ready === 1'b0) low_cnt++;
  endtask

  // Launch nsym symbols on dut, one tick every gap cycles, checking each and that it holds.
  task automatic frame(input int nsym, input int gap, input logic [15:0] exp, input string tag);
    for (int i = 0; i < nsym; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      check(tag, tx, exp[i]);
      for (int g = 1; g < gap; g++) begin
        step();
        check($sformatf("%s_hold", tag), tx, exp[i]);
      end
    end
  endtask

  // Tick that ends the last stop bit: dut must be idle afterwards.
  task automatic end_frame(input string tag);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check($sformatf("%s_ready", tag), ready, 1);
    check($sformatf("%s_tx", tag), tx, 1);
    check($sformatf("%s_busy", tag), busy, 0);
  endtask

  // dut2 has its tick tied high: one symbol per cycle after the accept cycle.
  task automatic frame2(input logic [7:0] d, input logic [15:0] exp, input string tag);
    data2  = d;
    valid2 = 1'b1;
    step();
    valid2 = 1'b0;
    check($sformatf("%s_acc_tx", tag), tx2, 1);
    check($sformatf("%s_acc_busy", tag), busy2, 1);
    for (int i = 0; i < N2; i++) begin
      step();
      check(tag, tx2, exp[i]);
    end
    step();
    check($sformatf("%s_idle_ready", tag), ready2, 1);
    check($sformatf("%s_idle_tx", tag), tx2, 1);
  endtask

  initial begin
    rst    = 1'b1;
    tick   = 1'b0;
    valid  = 1'b0;
    data   = 8'h00;
    valid2 = 1'b0;
    data2  = 8'h00;
    repeat (3) step();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_tx2", tx2, 1);
    rst = 1'b0;
    step();
    check("idle_ready", ready, 1);
    check("idle_tx", tx, 1);
    check("idle_busy", busy, 0);

    // 0xA5, tick every 4 clocks; ready stays low 4 clocks per symbol after the first tick.
    data  = 8'hA5;
    valid = 1'b1;
    step();
    valid = 1'b0;
    data  = 8'h00;
    check("a5_acc_ready", ready, 0);
    check("a5_acc_busy", busy, 1);
    check("a5_acc_tx", tx, 1);
    repeat (3) begin
      step();
      check("a5_pretick_tx", tx, 1);
    end
    low_cnt = 0;
    frame(N1, 4, FrA5, "a5");
    end_frame("a5_end");
    check("a5_ready_low_cycles", low_cnt, 4 * N1);

    // Back-to-back with valid held: 0x00 then 0xFF, data changes while busy are ignored.
    data  = 8'h00;
    valid = 1'b1;
    step();
    data  = 8'hFF;
    check("b2b_acc_ready", ready, 0);
    frame(N1, 2, Fr00, "f00");
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("b2b_gap_ready", ready, 1);
    step();
    check("b2b_reacc_ready", ready, 0);
    check("b2b_reacc_busy", busy, 1);
    valid = 1'b0;
    data  = 8'h12;
    frame(N1, 2, FrFF, "fff");
    end_frame("fff_end");

    // Tick coincident with accept is ignored.
    data  = 8'h5A;
    valid = 1'b1;
    tick  = 1'b1;
    step();
    valid = 1'b0;
    tick  = 1'b0;
    check("coinc_tx", tx, 1);
    check("coinc_ready", ready, 0);
    step();
    check("coinc_hold_tx", tx, 1);
    frame(N1, 1, Fr5A, "f5a");
    end_frame("f5a_end");

    // Asynchronous reset after D3 aborts the frame immediately.
    data  = 8'h0F;
    valid = 1'b1;
    step();
    valid = 1'b0;
    frame(5, 2, 16'h001E, "f0f");
    rst = 1'b1;
    #1;
    check("arst_tx", tx, 1);
    check("arst_busy", busy, 0);
    step();
    rst = 1'b0;
    repeat (3) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      check("post_rst_tx", tx, 1);
      check("post_rst_ready", ready, 1);
    end
    data  = 8'hC3;
    valid = 1'b1;
    step();
    valid = 1'b0;
    frame(N1, 2, FrC3, "fc3");
    end_frame("fc3_end");

    // Two stop bits, tick tied high.
    frame2(8'h3C, Fr3C, "t2_3c");
    frame2(8'h01, Fr01, "t2_01");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
